// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive framing engine.
// Holds the frame state encoding and the 2-of-3 vote helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int DEF_PRESCALE   = 8;
    localparam int DEF_DATA_WIDTH = 8;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/rx_data_sampling.sv
// Three-sample majority voter around the middle of each oversampled bit.
// The vote is registered one edge after the last sample and held until the next bit.
module rx_data_sampling
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_in,
    input  logic [$clog2(PRESCALE)-1:0] edge_cnt,
    output logic                        sampled_bit
);

    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] EDGE_S0  = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] EDGE_S1  = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] EDGE_S2  = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] EDGE_UPD = EW'(PRESCALE / 2 + 2);

    logic [2:0] samples;

    // NOTE: sample flops reset to 1 as well, so a vote taken before any real
    // capture reads as an idle (high) line rather than a phantom start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples     <= '1;
            sampled_bit <= 1'b1;
        end else begin
            case (edge_cnt)
                EDGE_S0:  samples[0]  <= rx_in;
                EDGE_S1:  samples[1]  <= rx_in;
                EDGE_S2:  samples[2]  <= rx_in;
                EDGE_UPD: sampled_bit <= majority3(samples);
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive framing engine: start detect, LSB-first deserialization,
// parity-checker handshake, stop check and a one-cycle DATA_VALID for clean frames.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  par_err,
    output logic                  par_chk_en,
    output logic                  sampled_bit,
    output logic                  par_typ_o,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    rx_state_e     state, next_state;
    logic [EW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          par_en_q;
    logic          bit_end;
    logic          start_det;

    assign bit_end   = (edge_cnt == LAST_EDGE);
    assign start_det = (state == IDLE) && !RX_IN;

    rx_data_sampling #(
        .PRESCALE(PRESCALE)
    ) u_sampling (
        .clk        (CLK),
        .rst_n      (RST),
        .rx_in      (RX_IN),
        .edge_cnt   (edge_cnt),
        .sampled_bit(sampled_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: defaults first, so no path through the case leaves an output
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        par_chk_en = 1'b0;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            START:  if (bit_end) next_state = sampled_bit ? IDLE : DATA;
            DATA:   if (bit_end && bit_cnt == LAST_BIT)
                        next_state = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) begin
                        par_chk_en = 1'b1;
                        next_state = STOP;
                    end
            STOP:   if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Edge 0 of the start bit is spent in IDLE, so the count resumes at 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state == IDLE)  edge_cnt <= start_det ? EW'(1) : '0;
            else if (bit_end)   edge_cnt <= '0;
            else                edge_cnt <= edge_cnt + 1'b1;

            if (state != DATA)  bit_cnt <= '0;
            else if (bit_end)   bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q   <= 1'b0;
            par_typ_o  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (start_det) begin
                par_en_q  <= PAR_EN;
                par_typ_o <= PAR_TYP;
                PAR_ERR   <= 1'b0;
                STP_ERR   <= 1'b0;
            end
            if (bit_end) begin
                case (state)
                    DATA:    P_DATA <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
                    PARITY:  PAR_ERR <= par_err;
                    STOP: begin
                        STP_ERR    <= ~sampled_bit;
                        DATA_VALID <= sampled_bit & ~PAR_ERR;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
